top_mul_pipe_rs: RTL and testbench



---
 rtl/top_mul_pkg.sv | 16 +
 rtl/top_mul_post_rs.sv | 49 ++++
 rtl/top_mul_pipe_rs.sv | 111 +++++++++++
 tb/tb_top_mul_pipe_rs.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/top_mul_pkg.sv
// Shared sizing helpers and stage limits for the pipelined fixed-point multiplier.
package top_mul_pkg;

  localparam int MAX_STAGE = 6;
  localparam int MIN_STAGE = 1;

  // Operands are each widened by one bit, so the signed product never loses bits.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  function automatic bit result_signed(input int s0, input int s1);
    return (s0 != 0) || (s1 != 0);
  endfunction

endpackage

// File: rtl/top_mul_post_rs.sv
// Combinational round / shift / truncate stage; clamps to the output range when TOP_MUL_SAT_EN is defined.
module top_mul_post_rs
  import top_mul_pkg::*;
#(
  parameter int P          = 62,
  parameter int RS         = 1,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int DOUT_WIDTH = 32
) (
  input  logic [P-1:0]          prod,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat
);

  // Working width leaves room for the rounding add and for comparing against the output limits.
  localparam int W = (P + 1 > DOUT_WIDTH + 2) ? P + 1 : DOUT_WIDTH + 2;
  localparam logic signed [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] HI  = (RS != 0) ? (ONE <<< (DOUT_WIDTH - 1)) - ONE
                                                  : (ONE <<< DOUT_WIDTH) - ONE;
  localparam logic signed [W-1:0] LO  = (RS != 0) ? -(ONE <<< (DOUT_WIDTH - 1)) : '0;
  localparam logic signed [W-1:0] RND = (ROUND != 0 && SHIFT > 0)
                                        ? ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0) : '0;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] wide;

  always_comb begin
    ext  = (RS != 0) ? W'(signed'(prod)) : W'(prod);
    ext  = ext + RND;
    wide = (RS != 0) ? (ext >>> SHIFT) : (ext >> SHIFT);
`ifdef TOP_MUL_SAT_EN
    if (wide > HI) begin
      dout = HI[DOUT_WIDTH-1:0];
      sat  = 1'b1;
    end else if (wide < LO) begin
      dout = LO[DOUT_WIDTH-1:0];
      sat  = 1'b1;
    end else begin
      dout = wide[DOUT_WIDTH-1:0];
      sat  = 1'b0;
    end
`else
    dout = wide[DOUT_WIDTH-1:0];
    sat  = 1'b0;
`endif
  end

endmodule

// File: rtl/top_mul_pipe_rs.sv
// Pipelined signed/unsigned multiplier with fixed-point output shift, valid bit and clock enable.
// Optional output saturation is enabled by defining TOP_MUL_SAT_EN.
module top_mul_pipe_rs
  import top_mul_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int DIN0_WIDTH  = 32,
  parameter int DIN1_WIDTH  = 28,
  parameter int DOUT_WIDTH  = 32,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int ROUND       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_vld,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_vld,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat
);

  localparam int P  = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int RS = result_signed(DIN0_SIGNED, DIN1_SIGNED) ? 1 : 0;

  if (NUM_STAGE < MIN_STAGE || NUM_STAGE > MAX_STAGE) begin : g_bad_stage
    $error("top_mul_pipe_rs: NUM_STAGE %0d out of range", NUM_STAGE);
  end
  if (SHIFT < 0 || SHIFT > DIN0_WIDTH + DIN1_WIDTH - 1) begin : g_bad_shift
    $error("top_mul_pipe_rs: SHIFT %0d out of range", SHIFT);
  end

  logic signed [DIN0_WIDTH:0] a_ext, a_op;
  logic signed [DIN1_WIDTH:0] b_ext, b_op;
  logic signed [P-1:0]        prod_c, prod_op;
  logic [DOUT_WIDTH-1:0]      post_dout;
  logic                       post_sat;
  logic [NUM_STAGE-1:0]       vld;

  always_comb begin
    a_ext = (DIN0_SIGNED != 0) ? {din0[DIN0_WIDTH-1], din0} : {1'b0, din0};
    b_ext = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
  end

  if (NUM_STAGE == 1) begin : g_op_comb
    always_comb begin
      a_op = a_ext;
      b_op = b_ext;
    end
  end else begin : g_op_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        a_op <= '0;
        b_op <= '0;
      end else if (ce) begin
        a_op <= a_ext;
        b_op <= b_ext;
      end
    end
  end

  always_comb prod_c = P'(a_op) * P'(b_op);

  // Product delay line between the operand and output registers; only exists for NUM_STAGE >= 3.
  if (NUM_STAGE <= 2) begin : g_prod_comb
    always_comb prod_op = prod_c;
  end else begin : g_prod_reg
    logic signed [P-1:0] prod_q [NUM_STAGE-2];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < NUM_STAGE - 2; i++) prod_q[i] <= '0;
      end else if (ce) begin
        prod_q[0] <= prod_c;
        for (int unsigned i = 1; i < NUM_STAGE - 2; i++) prod_q[i] <= prod_q[i-1];
      end
    end
    always_comb prod_op = prod_q[NUM_STAGE-3];
  end

  top_mul_post_rs #(
    .P          (P),
    .RS         (RS),
    .SHIFT      (SHIFT),
    .ROUND      (ROUND),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_post (
    .prod (prod_op),
    .dout (post_dout),
    .sat  (post_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= '0;
      dout <= '0;
      sat  <= 1'b0;
    end else if (ce) begin
      vld[0] <= in_vld;
      for (int unsigned i = 1; i < NUM_STAGE; i++) vld[i] <= vld[i-1];
      dout <= post_dout;
      sat  <= post_sat;
    end
  end

  always_comb out_vld = vld[NUM_STAGE-1];

endmodule

// File: tb/tb_top_mul_pipe_rs.sv
// Self-checking bench: three instances (plain, SHIFT=4 rounded, SHIFT=4 truncated) against an arithmetic model.
module tb_top_mul_pipe_rs;

  localparam int NS = 3;

  logic             clk = 1'b0;
  logic             reset, ce, in_vld;
  logic [31:0]      din0;
  logic [27:0]      din1;
  logic [2:0]       ov, sv;
  logic [2:0][31:0] dv;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  top_mul_pipe_rs #(.NUM_STAGE(NS)) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .din0(din0), .din1(din1),
    .out_vld(ov[0]), .dout(dv[0]), .sat(sv[0]));
  top_mul_pipe_rs #(.NUM_STAGE(NS), .SHIFT(4), .ROUND(1)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .din0(din0), .din1(din1),
    .out_vld(ov[1]), .dout(dv[1]), .sat(sv[1]));
  top_mul_pipe_rs #(.NUM_STAGE(NS), .SHIFT(4), .ROUND(0)) dut2 (
    .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .din0(din0), .din1(din1),
    .out_vld(ov[2]), .dout(dv[2]), .sat(sv[2]));

  typedef struct {
    logic [2:0][31:0] d;
    logic [2:0]       s;
    int               due;
  } item_t;

  item_t            q[$];
  logic             ev;
  logic [2:0][31:0] ed;
  logic [2:0]       es;
  int               cnt;
  bit               chk_zero;
  int               shf [3] = '{0, 4, 4};
  bit               rnd [3] = '{1'b0, 1'b1, 1'b0};

  // Full product as a 64-bit integer, then round, arithmetic shift, optional clamp, keep low 32 bits.
  function automatic void model(input logic [31:0] a, input logic [27:0] b, input int sh,
                                input bit r, output logic [31:0] d, output logic s);
    longint p;
    p = longint'($signed(a)) * longint'({4'b0, b});
    if (r && sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    s = 1'b0;
`ifdef TOP_MUL_SAT_EN
    if (p > 64'sd2147483647) begin
      p = 64'sd2147483647;
      s = 1'b1;
    end else if (p < -64'sd2147483648) begin
      p = -64'sd2147483648;
      s = 1'b1;
    end
`endif
    d = p[31:0];
  endfunction

  task automatic step(input bit r, input bit c, input bit v,
                      input logic [31:0] a, input logic [27:0] b);
    item_t it;
    reset = r; ce = c; in_vld = v; din0 = a; din1 = b;
    @(posedge clk);
    if (r) begin
      q.delete();
      ev = 1'b0;
      ed = '0;
      es = '0;
    end else if (c) begin
      cnt++;
      if (v) begin
        for (int i = 0; i < 3; i++) model(a, b, shf[i], rnd[i], it.d[i], it.s[i]);
        it.due = cnt + NS - 1;
        q.push_back(it);
      end
      ev = 1'b0;
      if (q.size() > 0 && q[0].due == cnt) begin
        ev = 1'b1;
        ed = q[0].d;
        es = q[0].s;
        void'(q.pop_front());
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      assert (ov[i] === ev) else begin
        fails++;
        $error("FAIL out_vld[%0d] got %b exp %b (t=%0t)", i, ov[i], ev, $time);
      end
      if (ev) begin
        tests++;
        assert (dv[i] === ed[i]) else begin
          fails++;
          $error("FAIL dout[%0d] got %h exp %h (t=%0t)", i, dv[i], ed[i], $time);
        end
        tests++;
        assert (sv[i] === es[i]) else begin
          fails++;
          $error("FAIL sat[%0d] got %b exp %b (t=%0t)", i, sv[i], es[i], $time);
        end
      end
      if (chk_zero) begin
        tests++;
        assert (dv[i] === 32'h0 && sv[i] === 1'b0) else begin
          fails++;
          $error("FAIL zero[%0d] got dout %h sat %b exp 0/0 (t=%0t)", i, dv[i], sv[i], $time);
        end
      end
    end
  endtask

  initial begin
    ev = 1'b0; ed = '0; es = '0; cnt = 0; chk_zero = 1'b0;
    reset = 1'b1; ce = 1'b0; in_vld = 1'b0; din0 = '0; din1 = '0;

    chk_zero = 1'b1;
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h1234_5678, 28'h0AB_CDEF);
    chk_zero = 1'b0;

    // Single item: -3 x 5
    step(0, 1, 1, 32'hFFFF_FFFD, 28'd5);
    repeat (4) step(0, 1, 0, 0, 0);

    // Back-to-back
    step(0, 1, 1, 32'd1, 28'd1);
    step(0, 1, 1, 32'd2, 28'd3);
    step(0, 1, 1, 32'hFFFF_FFFF, 28'd7);
    step(0, 1, 1, 32'd0, 28'd9);
    repeat (4) step(0, 1, 0, 0, 0);

    // Stall with one item in flight
    step(0, 1, 1, 32'd7, 28'd6);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'd99, 28'd99);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 32'd11, 28'd13);
    repeat (2) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // Reset with items in flight; input during reset is discarded
    step(0, 1, 1, 32'd5, 28'd5);
    step(0, 1, 1, 32'd9, 28'd9);
    step(1, 1, 1, 32'd3, 28'd3);
    chk_zero = 1'b1;
    repeat (6) step(0, 1, 0, 0, 0);
    chk_zero = 1'b0;

    // Rounding boundaries for the shifted instances
    step(0, 1, 1, 32'd3, 28'd3);
    step(0, 1, 1, 32'hFFFF_FFFD, 28'd3);
    step(0, 1, 1, 32'd8, 28'd1);
    step(0, 1, 1, 32'hFFFF_FFF8, 28'd1);
    repeat (4) step(0, 1, 0, 0, 0);

    // Overflow / saturation corners
    step(0, 1, 1, 32'h7FFF_FFFF, 28'h0FF_FFFF);
    step(0, 1, 1, 32'h8000_0000, 28'h0FF_FFFF);
    step(0, 1, 1, 32'h8000_0000, 28'd1);
    repeat (4) step(0, 1, 0, 0, 0);

    // Random traffic with random ce and occasional reset
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           $urandom, 28'($urandom));
    end
    repeat (8) step(0, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
